load_store_unit: RTL and testbench

Initiator-side load/store unit between the CPU execute stage and the word-addressed, synchronous-read data memory. Accepts RV32I load/store requests (byte, half, word; signed or unsigned), drives the memory's write-enable, word address, and write-data port, and returns extended load data. Sub-word stores use a read-modify-write sequence. Misaligned and illegal accesses are flagged without touching memory.

---
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Bundle of the CPU request/response and data-memory signals
//               seen by the load/store unit.
//               slave  - the load/store unit itself.
//               master - the surrounding environment (execute stage + memory).
// Signals     : req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
//               resp_valid/resp_rdata/resp_err
//               mem_we/mem_addr/mem_wdata/mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-3:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store unit in front of a word-addressed,
//               synchronous-read data memory. Byte/half stores are done as
//               read-modify-write; misaligned or illegal requests return an
//               error without any memory write.
// Ports       : clk   - clock, all state on the rising edge
//               rst_n - asynchronous active-low reset
//               bus   - load_store_unit_if.slave (request, response, memory)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [2:0] C_F3_B  = 3'b000;
  localparam logic [2:0] C_F3_H  = 3'b001;
  localparam logic [2:0] C_F3_W  = 3'b010;
  localparam logic [2:0] C_F3_BU = 3'b100;
  localparam logic [2:0] C_F3_HU = 3'b101;

  logic [1:0]               r_state;
  logic [2:0]               r_funct3;
  logic                     r_we;
  logic [1:0]               r_lane;
  logic [15:0]              r_wdata;      // only the low half is ever merged
  logic                     r_mem_we;
  logic [ADDRESS_WIDTH-3:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic [DATA_WIDTH-1:0]    r_resp_rdata;
  logic                     r_resp_err;

  logic                     w_f3_bad;
  logic                     w_misaligned;
  logic                     w_err;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [DATA_WIDTH-1:0]    w_load_data;
  logic [DATA_WIDTH-1:0]    w_merge;

  // Request legality, evaluated on the raw request inputs in IDLE.
  always_comb begin
    w_f3_bad     = 1'b0;
    w_misaligned = 1'b0;
    if (bus.req_we) begin
      w_f3_bad = (bus.req_funct3 != C_F3_B) && (bus.req_funct3 != C_F3_H) &&
                 (bus.req_funct3 != C_F3_W);
    end else begin
      w_f3_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                 (bus.req_funct3 == 3'b111);
    end
    if (((bus.req_funct3 == C_F3_H) || (bus.req_funct3 == C_F3_HU)) &&
        bus.req_addr[0]) begin
      w_misaligned = 1'b1;
    end
    if ((bus.req_funct3 == C_F3_W) && (bus.req_addr[1:0] != 2'b00)) begin
      w_misaligned = 1'b1;
    end
    w_err = w_f3_bad || w_misaligned;
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    w_byte  = bus.mem_rdata[{r_lane, 3'b000} +: 8];
    w_half  = bus.mem_rdata[{r_lane[1], 4'b0000} +: 16];
    w_load_data = bus.mem_rdata;
    case (r_funct3)
      C_F3_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
      C_F3_BU: w_load_data = {24'd0, w_byte};
      C_F3_H:  w_load_data = {{16{w_half[15]}}, w_half};
      C_F3_HU: w_load_data = {16'd0, w_half};
      default: w_load_data = bus.mem_rdata;
    endcase
    w_merge = bus.mem_rdata;
    if (r_funct3 == C_F3_B) begin
      w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_funct3     <= 3'd0;
      r_we         <= 1'b0;
      r_lane       <= 2'd0;
      r_wdata      <= 16'd0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_funct3   <= bus.req_funct3;
            r_we       <= bus.req_we;
            r_lane     <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata[15:0];
            r_mem_addr <= bus.req_addr[ADDRESS_WIDTH-1:2];
            if (w_err) begin
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= ST_RESP;
            end else if (bus.req_we && (bus.req_funct3 == C_F3_W)) begin
              // Full-word store needs no read; it commits at the end of RESP.
              r_mem_we     <= 1'b1;
              r_mem_wdata  <= bus.req_wdata;
              r_resp_rdata <= '0;
              r_state      <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Memory samples the read address at the end of this cycle.
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (r_we) begin
            r_mem_wdata  <= w_merge;
            r_mem_we     <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_resp_rdata <= w_load_data;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_mem_we   <= 1'b0;
          r_resp_err <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A behavioural
//               reference model predicts each response and each memory write
//               at issue time; a monitor compares them as the DUT produces
//               them. A 16-word memory model (aliased on the low index bits)
//               sits on the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous-read memory: write when we=1, otherwise register a read.
  logic [31:0] mem [16];
  logic [31:0] mem_rd = 32'd0;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    else            mem_rd <= mem[bus.mem_addr[3:0]];
  end
  assign bus.mem_rdata = mem_rd;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t       resp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ref_mem [16];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_acc   = 0;
  int          n_drop  = 0;
  int          n_resp  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: RV32I load/store semantics on a flat word array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat, output bit wr,
                       output logic [31:0] wword);
    int          idx;
    int          sh;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] mask;
    idx   = int'(addr[5:2]);
    sh    = 8 * int'(addr[1:0]);
    word  = ref_mem[idx];
    rdata = 32'd0;
    err   = 1'b0;
    lat   = 3;
    wr    = 1'b0;
    wword = 32'd0;
    if (we) err = !(f3 inside {3'd0, 3'd1, 3'd2});
    else    err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) err = 1'b1;
    if (f3 == 3'd2 && addr[1:0] != 2'd0) err = 1'b1;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = word >> sh;
      case (f3)
        3'd0:    rdata = 32'($signed(v[7:0]));
        3'd1:    rdata = 32'($signed(v[15:0]));
        3'd4:    rdata = v & 32'h0000_00FF;
        3'd5:    rdata = v & 32'h0000_FFFF;
        default: rdata = word;
      endcase
    end else begin
      wr = 1'b1;
      if (f3 == 3'd2) begin
        wword = wdata;
        lat   = 1;
      end else begin
        mask  = ((f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        wword = (word & ~mask) | ((wdata << sh) & mask);
      end
      ref_mem[idx] = wword;
    end
  endtask

  // Present one request (req_valid stays high afterwards) and wait for accept.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int          guard;
    resp_t       r;
    wr_t         w;
    bit          wr;
    logic [31:0] wword;
    guard = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    while (!bus.req_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 20) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout actual=no_accept required=accept_within_20");
        return;
      end
    end
    model(we, f3, addr, wdata, r.rdata, r.err, r.lat, wr, wword);
    r.acc = cyc;
    resp_q.push_back(r);
    if (wr) begin
      w.addr = addr[31:2];
      w.data = wword;
      wr_q.push_back(w);
    end
    @(posedge clk);
    n_acc++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
    check32({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check32({tag, "_resp_rdata"}, bus.resp_rdata,      32'd0);
    check32({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
    check32({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    check32({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
    check32({tag, "_mem_wdata"},  bus.mem_wdata,       32'd0);
  endtask

  // Monitor: ready tracking, response scoreboard and write scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      resp_t r;
      wr_t   w;
      check32("req_ready", 32'(bus.req_ready), 32'((n_acc - n_drop) == n_resp));
      if (bus.resp_valid) begin
        if (resp_q.size() == 0) begin
          check32("unexpected_resp", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          check32("resp_rdata",   bus.resp_rdata,     r.rdata);
          check32("resp_err",     32'(bus.resp_err),  32'(r.err));
          check32("resp_latency", 32'(cyc - r.acc),   32'(r.lat));
        end
        n_resp++;
      end
      if (bus.mem_we) begin
        if (wr_q.size() == 0) begin
          check32("unexpected_mem_we", 32'(bus.mem_addr), 32'hFFFF_FFFF);
        end else begin
          w = wr_q.pop_front();
          check32("mem_addr",  32'(bus.mem_addr), 32'(w.addr));
          check32("mem_wdata", bus.mem_wdata,     w.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] saved;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    #3 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill memory through the DUT, then preload word 1.
    for (int i = 0; i < 16; i++) issue(1'b1, 3'd2, 32'(4 * i), $urandom);
    issue(1'b1, 3'd2, 32'h4, 32'h80FF_7F01);

    // Loads from word 1, back-to-back.
    issue(1'b0, 3'd0, 32'h7, 32'd0);   // LB
    issue(1'b0, 3'd4, 32'h7, 32'd0);   // LBU
    issue(1'b0, 3'd1, 32'h6, 32'd0);   // LH
    issue(1'b0, 3'd5, 32'h4, 32'd0);   // LHU
    issue(1'b0, 3'd2, 32'h4, 32'd0);   // LW
    // Read-modify-write byte store, then read it back.
    issue(1'b1, 3'd0, 32'h5, 32'h1234_56AB);
    issue(1'b0, 3'd2, 32'h4, 32'd0);
    issue(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF);
    issue(1'b1, 3'd1, 32'hE, 32'hCAFE_5A5A);  // SH upper half
    issue(1'b0, 3'd2, 32'hC, 32'd0);
    // Errors.
    issue(1'b1, 3'd1, 32'h5, 32'h1111_1111);  // SH misaligned
    issue(1'b0, 3'd2, 32'h6, 32'd0);          // LW misaligned
    issue(1'b0, 3'd3, 32'h0, 32'd0);          // illegal load funct3
    issue(1'b1, 3'd4, 32'h0, 32'h2222_2222);  // illegal store funct3
    issue(1'b0, 3'd5, 32'h3, 32'd0);          // LHU misaligned
    // Top-of-range addresses: word index truncated, no error.
    issue(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h0BAD_F00D);
    issue(1'b0, 3'd2, 32'hFFFF_FFF0, 32'd0);
    issue(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd0);
    idle(3);

    // Reset during CAPTURE of a byte store: write must not commit.
    saved = ref_mem[2];
    issue(1'b1, 3'd0, 32'h9, 32'h0000_0077);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    resp_q.delete();
    wr_q.delete();
    n_drop = n_acc - n_resp;
    ref_mem[2] = saved;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 3'd2, 32'h8, 32'd0);
    issue(1'b1, 3'd0, 32'hA, 32'h0000_0099);
    issue(1'b0, 3'd2, 32'h8, 32'd0);
    idle(2);

    // Randomized traffic with occasional gaps.
    for (int i = 0; i < 300; i++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), f3, addr, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(8);

    check32("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    check32("write_queue_empty", 32'(wr_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) check32($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
